// File: rtl/sum_accumulator_28b_if.sv
// sum_accumulator_28b_if: sum stream in, frame result out, with start/ready handshake
interface sum_accumulator_28b_if;
    logic        start;
    logic [7:0]  len;
    logic [28:0] sum_in;
    logic        sum_valid;
    logic [36:0] acc_out;
    logic [28:0] max_out;
    logic [7:0]  cnt_out;
    logic        acc_valid;
    logic        acc_ready;
    logic        busy;
    modport master (
        output start, len, sum_in, sum_valid, acc_ready,
        input  acc_out, max_out, cnt_out, acc_valid, busy
    );
    modport slave (
        input  start, len, sum_in, sum_valid, acc_ready,
        output acc_out, max_out, cnt_out, acc_valid, busy
    );
endinterface

// File: rtl/sum_accumulator_28b.sv
// sum_accumulator_28b: accumulates len 29-bit sums per frame into a 37-bit total plus running max
module sum_accumulator_28b (
    input logic              clk,
    input logic              rstn,
    sum_accumulator_28b_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t      state, state_nxt;
    logic [36:0] acc;
    logic [28:0] mx;
    logic [7:0]  cnt, len_q;
    logic        start_ok, take, last;
    // a start in DONE only counts when it also consumes the pending result
    assign start_ok = bus.start && (state == IDLE || (state == DONE && bus.acc_ready));
    assign take     = state == ACCUM && bus.sum_valid;
    assign last     = take && (cnt + 8'd1) == len_q;
    always_comb begin
        state_nxt = state;
        if (start_ok)
            state_nxt = ACCUM;
        else if (last)
            state_nxt = DONE;
        else if (state == DONE && bus.acc_ready)
            state_nxt = IDLE;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            acc   <= '0;
            mx    <= '0;
            cnt   <= '0;
            len_q <= 8'd1;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                acc   <= '0;
                mx    <= '0;
                cnt   <= '0;
                len_q <= bus.len == 8'd0 ? 8'd1 : bus.len;
            end else if (take) begin
                acc <= acc + {8'd0, bus.sum_in};
                mx  <= bus.sum_in > mx ? bus.sum_in : mx;
                cnt <= cnt + 8'd1;
            end
        end
    end
    assign bus.acc_out   = acc;
    assign bus.max_out   = mx;
    assign bus.cnt_out   = cnt;
    assign bus.acc_valid = state == DONE;
    assign bus.busy      = state == ACCUM;
endmodule

// File: tb/tb_sum_accumulator_28b.sv
// tb_sum_accumulator_28b: directed checks of framing, gaps, backpressure, chaining and reset
module tb_sum_accumulator_28b;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad = 0;
    sum_accumulator_28b_if bus ();
    sum_accumulator_28b dut (.clk(clk), .rstn(rstn), .bus(bus));
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic begin_frame(input logic [7:0] n);
        bus.start = 1'b1;
        bus.len   = n;
        step();
        bus.start = 1'b0;
    endtask

    task automatic push(input logic [28:0] s);
        bus.sum_valid = 1'b1;
        bus.sum_in    = s;
        step();
        bus.sum_valid = 1'b0;
    endtask

    task automatic handshake();
        bus.acc_ready = 1'b1;
        step();
        bus.acc_ready = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.len = 8'd0;
        bus.sum_in = '0;
        bus.sum_valid = 1'b0;
        bus.acc_ready = 1'b0;
        #3;
        chk("rst_acc", bus.acc_out, 37'd0);
        chk("rst_valid", {36'd0, bus.acc_valid}, 37'd0);
        chk("rst_busy", {36'd0, bus.busy}, 37'd0);
        step();
        rstn = 1'b1;
        step();

        // reset in the middle of a frame
        begin_frame(8'd4);
        chk("mid_busy", {36'd0, bus.busy}, 37'd1);
        push(29'h3);
        push(29'h4);
        chk("mid_cnt", {29'd0, bus.cnt_out}, 37'd2);
        chk("mid_acc", bus.acc_out, 37'h7);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_acc", bus.acc_out, 37'd0);
        chk("async_max", {8'd0, bus.max_out}, 37'd0);
        chk("async_cnt", {29'd0, bus.cnt_out}, 37'd0);
        chk("async_busy", {36'd0, bus.busy}, 37'd0);
        step();
        rstn = 1'b1;
        begin_frame(8'd1);
        push(29'h5);
        chk("post_rst_valid", {36'd0, bus.acc_valid}, 37'd1);
        chk("post_rst_acc", bus.acc_out, 37'h5);
        handshake();
        chk("hs_valid", {36'd0, bus.acc_valid}, 37'd0);
        chk("hs_hold_acc", bus.acc_out, 37'h5);

        // basic back-to-back frame
        begin_frame(8'd3);
        push(29'h0000001);
        push(29'h0FFFFFFF);
        chk("basic_not_yet", {36'd0, bus.acc_valid}, 37'd0);
        push(29'h1FFFFFFF);
        chk("basic_valid", {36'd0, bus.acc_valid}, 37'd1);
        chk("basic_acc", bus.acc_out, 37'h2FFFFFFF);
        chk("basic_max", {8'd0, bus.max_out}, 37'h1FFFFFFF);
        chk("basic_cnt", {29'd0, bus.cnt_out}, 37'd3);
        chk("basic_busy", {36'd0, bus.busy}, 37'd0);
        push(29'h100);
        chk("done_ignores_sum", bus.acc_out, 37'h2FFFFFFF);
        handshake();
        push(29'h100);
        chk("idle_ignores_sum", bus.acc_out, 37'h2FFFFFFF);

        // gapped valid, then backpressure with start pulses in DONE
        begin_frame(8'd2);
        push(29'h10);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gap_cnt", {29'd0, bus.cnt_out}, 37'd1);
        end
        push(29'h20);
        chk("gap_acc", bus.acc_out, 37'h30);
        chk("gap_max", {8'd0, bus.max_out}, 37'h20);
        chk("gap_valid", {36'd0, bus.acc_valid}, 37'd1);
        for (int i = 0; i < 5; i++) begin
            bus.start = (i % 2) == 0;
            bus.len = 8'd1;
            step();
            chk("bp_valid", {36'd0, bus.acc_valid}, 37'd1);
            chk("bp_acc", bus.acc_out, 37'h30);
        end
        bus.start = 1'b1;
        bus.acc_ready = 1'b1;
        bus.len = 8'd1;
        step();
        bus.acc_ready = 1'b0;
        chk("chain_busy", {36'd0, bus.busy}, 37'd1);
        chk("chain_cnt", {29'd0, bus.cnt_out}, 37'd0);
        chk("chain_acc", bus.acc_out, 37'd0);
        step();
        bus.start = 1'b0;
        chk("accum_ignores_start", {36'd0, bus.busy}, 37'd1);
        push(29'h9);
        chk("chain_result", bus.acc_out, 37'h9);
        chk("chain_done", {36'd0, bus.acc_valid}, 37'd1);
        handshake();

        // len=0 behaves as len=1
        begin_frame(8'd0);
        push(29'h7);
        chk("len0_valid", {36'd0, bus.acc_valid}, 37'd1);
        chk("len0_acc", bus.acc_out, 37'h7);
        handshake();

        // full-length frame of maximum sums
        begin_frame(8'd255);
        for (int i = 0; i < 254; i++) push(29'h1FFFFFFF);
        chk("max_not_yet", {36'd0, bus.acc_valid}, 37'd0);
        push(29'h1FFFFFFF);
        chk("max_valid", {36'd0, bus.acc_valid}, 37'd1);
        chk("max_acc", bus.acc_out, 37'h1FDFFFFF01);
        chk("max_cnt", {29'd0, bus.cnt_out}, 37'd255);
        chk("max_max", {8'd0, bus.max_out}, 37'h1FFFFFFF);
        handshake();
        chk("final_idle", {36'd0, bus.acc_valid}, 37'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
